// File: rtl/uart_dpram_stream_ctrl_pkg.sv
// rtl/uart_dpram_stream_ctrl_pkg.sv - shared FSM state and mode encodings
package uart_dpram_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT_TX = 2'd3
    } state_t;

    localparam logic MODE_DRAIN  = 1'b0;
    localparam logic MODE_REPLAY = 1'b1;

endpackage

// File: rtl/uart_dpram_ptr_track.sv
// rtl/uart_dpram_ptr_track.sv - circular buffer write/read pointers, fill count and sticky overflow
module uart_dpram_ptr_track #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr_req,
    input  logic              i_inc_rd,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_ptr,
    output logic [ADDR_W-1:0] o_rd_ptr,
    output logic [ADDR_W:0]   o_fill_count,
    output logic              o_empty,
    output logic              o_overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_fill;
    logic              r_overflow;
    logic              w_full;
    logic              w_wr_en;
    logic              w_rd_en;

    assign w_full  = (r_fill == FULL_CNT);
    assign o_empty = (r_fill == '0);
    // Clear wins over any write or consume arriving in the same cycle.
    assign w_wr_en = i_wr_req && !w_full && !i_clr;
    assign w_rd_en = i_inc_rd && !o_empty && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_wr_req && w_full) r_overflow <= 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign o_wr_en      = w_wr_en;
    assign o_wr_ptr     = r_wr_ptr;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_fill_count = r_fill;
    assign o_overflow   = r_overflow;

endmodule

// File: rtl/uart_dpram_stream_ctrl.sv
// rtl/uart_dpram_stream_ctrl.sv - UART rx -> dual-port RAM ring buffer -> UART tx, drain or replay
module uart_dpram_stream_ctrl
    import uart_dpram_stream_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_uart_rx_done,
    input  logic              i_key_flag,
    input  logic              i_key_state,
    input  logic              i_mode,
    input  logic              i_clr,
    input  logic              i_uart_tx_done,
    output logic [ADDR_W-1:0] o_wraddress,
    output logic              o_ram_wren,
    output logic [ADDR_W-1:0] o_rdaddress,
    output logic              o_uart_send_en,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_fill_count,
    output logic              o_overflow
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t            r_state;
    logic              r_busy;
    logic              r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_offset;
    logic [1:0]        r_lat;

    logic              w_key_evt;
    logic              w_start;
    logic              w_stop;
    logic              w_inc_rd;
    logic              w_wr_en;
    logic              w_empty;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   w_fill;
    logic              w_have_data;
    logic              w_more;

    assign w_key_evt = i_key_flag && !i_key_state;
    assign w_start   = w_key_evt && !r_busy;
    assign w_stop    = w_key_evt && r_busy;
    assign w_inc_rd  = (r_state == ST_WAIT_TX) && i_uart_tx_done && (r_mode == MODE_DRAIN);

    uart_dpram_ptr_track #(.ADDR_W(ADDR_W)) u_ptr (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (i_clr),
        .i_wr_req     (i_uart_rx_done),
        .i_inc_rd     (w_inc_rd),
        .o_wr_en      (w_wr_en),
        .o_wr_ptr     (o_wraddress),
        .o_rd_ptr     (w_rd_ptr),
        .o_fill_count (w_fill),
        .o_empty      (w_empty),
        .o_overflow   (o_overflow)
    );

    // A byte landing this cycle counts as available so the send follows the write by RD_LAT+1.
    assign w_have_data = (r_mode == MODE_DRAIN) ? (!w_empty || w_wr_en) : (r_len != '0);
    assign w_more      = (r_mode == MODE_DRAIN) ? ((w_fill[ADDR_W:1] != '0) || w_wr_en) : 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_mode   <= MODE_DRAIN;
            r_base   <= '0;
            r_len    <= '0;
            r_offset <= '0;
            r_lat    <= '0;
        end else if (i_clr) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_offset <= '0;
            r_lat    <= '0;
        end else begin
            if (w_start) begin
                r_mode <= i_mode;
                r_busy <= (i_mode == MODE_DRAIN) || (w_fill != '0);
                if (i_mode == MODE_REPLAY) begin
                    r_base   <= w_rd_ptr;
                    r_len    <= w_fill;
                    r_offset <= '0;
                end
            end else if (w_stop) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_busy && !w_stop && w_have_data) begin
                        r_state <= ST_LOAD;
                        r_lat   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_stop)                 r_state <= ST_IDLE;
                    else if (r_lat == LAT_LAST) r_state <= ST_SEND;
                    else                        r_lat   <= r_lat + 1'b1;
                end
                ST_SEND: r_state <= w_stop ? ST_IDLE : ST_WAIT_TX;
                ST_WAIT_TX: begin
                    // A stop here only clears Busy; the byte in flight is still accounted.
                    if (i_uart_tx_done) begin
                        if (r_mode == MODE_REPLAY)
                            r_offset <= (r_offset + 1'b1 == r_len) ? '0 : r_offset + 1'b1;
                        if (r_busy && !w_stop && w_more) begin
                            r_state <= ST_LOAD;
                            r_lat   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ram_wren     = w_wr_en;
    assign o_rdaddress    = (r_mode == MODE_DRAIN) ? w_rd_ptr : r_base + r_offset[ADDR_W-1:0];
    assign o_uart_send_en = (r_state == ST_SEND) && !w_stop && !i_clr;
    assign o_busy         = r_busy;
    assign o_fill_count   = w_fill;

endmodule
